// File: rtl/vmem_requestor.sv
// Memory requestor: turns one read/write command into a burst between the lane streams and memory.
// Optional macro VMEM_REQ_ADDR_CHECK_EN rejects incrementing commands that run past ADDR_RANGE.
module vmem_requestor #(
    parameter int unsigned ADDR_RANGE   = 32768,
    parameter int unsigned LENGTH_RANGE = 32,
    parameter int unsigned BUS_WIDTH    = 32,
    localparam int unsigned AW = $clog2(ADDR_RANGE),
    localparam int unsigned LW = $clog2(LENGTH_RANGE) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_rd_i,
    input  logic [AW-1:0]        cmd_addr_i,
    input  logic [LW-1:0]        cmd_length_i,
    input  logic [1:0]           cmd_mode_i,
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    input  logic [BUS_WIDTH-1:0] wdata_i,
    output logic                 rdata_valid_o,
    output logic [BUS_WIDTH-1:0] rdata_o,
    input  logic                 rdata_ready_i,
    output logic                 done_o,
    output logic                 cmd_err_o,
    output logic                 wr_o,
    output logic                 rd_o,
    output logic                 rddataready_o,
    output logic [BUS_WIDTH-1:0] wrdata_o,
    output logic [AW-1:0]        addr_o,
    output logic [LW-1:0]        length_o,
    output logic [1:0]           mode_in_o,
    input  logic                 ready_i,
    input  logic                 rddatavalid_i,
    input  logic [BUS_WIDTH-1:0] rddata_i
);

    typedef enum logic [2:0] {StIdle, StRdReq, StRdData, StWrData, StDone} state_e;

    state_e               state_q;
    logic [AW-1:0]        addr_q;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        cnt_q;
    logic [1:0]           mode_q;
    logic                 rvalid_q;
    logic [BUS_WIDTH-1:0] rdata_q;
    logic                 done_q;
    logic                 err_q;

    logic cmd_fire;
    logic cmd_bad;
    logic wr_beat;
    logic rd_beat;
    logic last_beat;

    assign cmd_fire = cmd_valid_i && cmd_ready_o;

`ifdef VMEM_REQ_ADDR_CHECK_EN
    logic [AW:0] cmd_end;
    assign cmd_end = {1'b0, cmd_addr_i} + (AW+1)'(cmd_length_i);
    assign cmd_bad = (cmd_mode_i == 2'd1) && (cmd_end > (AW+1)'(ADDR_RANGE));
`else
    assign cmd_bad = 1'b0;
`endif

    // Handshake outputs are forced low while reset is held.
    always_comb begin
        cmd_ready_o   = 1'b0;
        wr_o          = 1'b0;
        rd_o          = 1'b0;
        wdata_ready_o = 1'b0;
        rddataready_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                StIdle:   cmd_ready_o = 1'b1;
                StRdReq:  rd_o = 1'b1;
                StRdData: rddataready_o = !rvalid_q || rdata_ready_i;
                StWrData: begin
                    wr_o          = wdata_valid_i;
                    wdata_ready_o = ready_i;
                end
                default: ;
            endcase
        end
    end

    assign wr_beat   = wr_o && ready_i;
    assign rd_beat   = rddataready_o && rddatavalid_i;
    assign last_beat = (cnt_q == len_q - LW'(1));

    assign wrdata_o      = wdata_i;
    assign addr_o        = addr_q;
    assign length_o      = len_q;
    assign mode_in_o     = mode_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q && !rst_i;
    assign done_o        = done_q && !rst_i;
    assign cmd_err_o     = err_q && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            mode_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            err_q  <= cmd_fire && cmd_bad;
            // One-entry output buffer; the final beat may drain after done.
            if (rd_beat) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rddata_i;
            end else if (rdata_ready_i) begin
                rvalid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (cmd_fire && !cmd_bad) begin
                        addr_q <= cmd_addr_i;
                        len_q  <= cmd_length_i;
                        mode_q <= cmd_mode_i;
                        cnt_q  <= '0;
                        if (cmd_length_i == '0) begin
                            state_q <= StDone;
                        end else if (cmd_rd_i) begin
                            state_q <= StRdReq;
                        end else begin
                            state_q <= StWrData;
                        end
                    end
                end
                StRdReq: begin
                    if (ready_i) state_q <= StRdData;
                end
                StRdData: begin
                    if (rd_beat) begin
                        cnt_q <= cnt_q + LW'(1);
                        if (last_beat) state_q <= StDone;
                    end
                end
                StWrData: begin
                    if (wr_beat) begin
                        cnt_q <= cnt_q + LW'(1);
                        if (last_beat) state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/vmem_requestor.md
VMEM_REQUESTOR -- requirements
Module: vmem_requestor

Interface
REQ-001 Parameter ADDR_RANGE, default 32768, number of addressable memory words; AW = $clog2(ADDR_RANGE).
REQ-002 Parameter LENGTH_RANGE, default 32, maximum beats per transaction; LW = $clog2(LENGTH_RANGE)+1.
REQ-003 Parameter BUS_WIDTH, default 32, data beat width in bits.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake; a command transfers when both are high.
REQ-007 cmd_rd  in  1  1 = read, 0 = write.
REQ-008 cmd_addr  in  AW  start word address.
REQ-009 cmd_length  in  LW  beat count, 0..LENGTH_RANGE.
REQ-010 cmd_mode  in  2  1 = incrementing address, any other value = fixed address.
REQ-011 wdata_valid/wdata_ready  in/out  1/1, wdata  in  BUS_WIDTH  write-data stream from lanes.
REQ-012 rdata_valid  out  1, rdata  out  BUS_WIDTH, rdata_ready  in  1  read-data stream to lanes.
REQ-013 done  out  1  one-cycle pulse at transaction end; cmd_err  out  1  one-cycle pulse on command rejection.
REQ-014 Memory side: wr, rd, rddataready  out  1; wrdata  out  BUS_WIDTH; addr  out  AW; length  out  LW; mode_in  out  2; ready, rddatavalid  in  1; rddata  in  BUS_WIDTH.

Function
REQ-015 FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, DONE; cmd_ready is high only in IDLE.
REQ-016 On command transfer, cmd_addr, cmd_length and cmd_mode are latched and drive addr, length and mode_in unchanged until the cycle after done.
REQ-017 IDLE -> RD_REQ on a read transfer; IDLE -> WR_DATA on a write transfer; IDLE -> DONE when cmd_length==0, with no wr/rd activity.
REQ-018 RD_REQ drives rd=1 for exactly one cycle, gated by ready=1 (rd is held until ready is sampled high); next state is RD_DATA.
REQ-019 wr and rd are never high in the same cycle; rd is never high outside RD_REQ.
REQ-020 RD_DATA: rddataready = !rdata_valid || rdata_ready; a beat is captured into a one-entry output register when rddatavalid && rddataready.
REQ-021 rdata_valid is held until rdata_ready is high; rdata is stable while rdata_valid && !rdata_ready.
REQ-022 A beat counter (LW bits) clears at command transfer and increments per accepted beat; after beat length-1 is captured, RD_DATA -> DONE.
REQ-023 WR_DATA: wr = wdata_valid; wrdata = wdata; wdata_ready = ready; a beat is accepted when wr && ready.
REQ-024 After beat length-1 is accepted (immediately for length==1), WR_DATA -> DONE; wr is low in DONE.
REQ-025 DONE asserts done for one cycle, then -> IDLE; in read mode, DONE is entered only once the final beat has been captured, and the final rdata may still be pending handshake.
REQ-026 Zero-latency path: none; the first rd is issued one cycle after command transfer, and the first wr is at the earliest one cycle after command transfer.
REQ-027 Beat-count arithmetic does not wrap; address generation is the memory's responsibility (addr is never incremented here).

Reset
REQ-028 rst high at a clock edge forces IDLE and clears the counter; done=0, cmd_err=0, rdata_valid=0, wr=0, rd=0, rddataready=0, wdata_ready=0, cmd_ready=0 during reset.
REQ-029 Reset mid-transaction abandons it without a done pulse; the same rst also resets the memory.
REQ-030 cmd_ready rises in the first cycle after rst deasserts.

Configuration
REQ-031 Macro VMEM_REQ_ADDR_CHECK_EN defined: a command is rejected when cmd_mode==1 and cmd_addr+cmd_length > ADDR_RANGE (computed at AW+1 bits); rejection pulses cmd_err, leaves the FSM in IDLE, and produces no memory activity or done pulse.
REQ-032 Macro VMEM_REQ_ADDR_CHECK_EN undefined: all commands are accepted, and cmd_err is tied 0.

Verification
REQ-033 Write addr=0x10, len=4, mode=1, wdata 0xA..0xD continuous, ready=1 -> 4 wr beats in consecutive cycles, one done pulse, then readback gives 0xA..0xD.
REQ-034 Read addr=0x10, len=4, mode=1, rdata_ready toggling 1/0 -> rd high for exactly 1 cycle, rdata 0xA,0xB,0xC,0xD in order with none dropped or duplicated, then done.
REQ-035 Write len=1 with wdata_valid delayed 5 cycles -> wr stays low 5 cycles, then 1 beat is accepted, then done.
REQ-036 len=0 command -> no wr or rd; done pulses 2 cycles after command transfer.
REQ-037 rst asserted during beat 2 of a len=8 read -> all outputs are 0 next cycle, no done pulse, and cmd_ready=1 the cycle after rst drops.
REQ-038 With VMEM_REQ_ADDR_CHECK_EN: addr=32760, len=16, mode=1 -> cmd_err=1 for 1 cycle, no wr/rd; addr=32760, len=8 -> accepted.
